// File: rtl/sigmoid_deriv_backprop.sv
// Sigmoid backward pass: delta = g * y * (1 - y) in Q16.16, using iterative shift-add multipliers.
// Define SIGDERIV_ERR_MUL_EN to build the gradient multiply (MUL2); otherwise delta = y * (1 - y).
module sigmoid_deriv_backprop (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y,
    input  logic [31:0] g,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] delta,
    output logic        y_clamped
);

    localparam int unsigned DW  = 32;
    localparam int unsigned YW  = 17;
    localparam int unsigned PW1 = 34;
    localparam int unsigned CW  = 5;
`ifdef SIGDERIV_ERR_MUL_EN
    localparam int unsigned DDW = 15;
    localparam int unsigned PW2 = 47;
`endif

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, FIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW1-1:0]  p1, mc1, p1_sum;
    logic [YW-1:0]   mp1;
    logic [YW-1:0]   yc_c;
    logic            clamp_c;
    logic            accept_c;
`ifdef SIGDERIV_ERR_MUL_EN
    logic [PW2-1:0]  p2, mc2, p2_sum;
    logic [DDW-1:0]  mp2;
    logic            sg;
    logic [DW-2:0]   m_c;
`else
    logic            g_unused;
    assign g_unused = ^g;
`endif

    assign accept_c = (state == IDLE) && in_valid;

    // Clamp y into [0, 1.0] at capture
    always_comb begin
        yc_c    = y[YW-1:0];
        clamp_c = 1'b0;
        if (y[DW-1]) begin
            yc_c    = '0;
            clamp_c = 1'b1;
        end else if (y > 32'h0001_0000) begin
            yc_c    = 17'h1_0000;
            clamp_c = 1'b1;
        end
    end

    assign p1_sum = p1 + (mp1[0] ? mc1 : '0);
`ifdef SIGDERIV_ERR_MUL_EN
    assign p2_sum = p2 + (mp2[0] ? mc2 : '0);
    assign m_c    = p2[PW2-1:16];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL1;
`ifdef SIGDERIV_ERR_MUL_EN
            MUL1: if (cnt == CW'(16)) state_nxt = MUL2;
            MUL2: if (cnt == CW'(14)) state_nxt = FIN;
`else
            MUL1: if (cnt == CW'(16)) state_nxt = FIN;
`endif
            FIN:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, two shift-add passes, sign restore
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            p1        <= '0;
            mc1       <= '0;
            mp1       <= '0;
            delta     <= '0;
            y_clamped <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef SIGDERIV_ERR_MUL_EN
            p2        <= '0;
            mc2       <= '0;
            mp2       <= '0;
            sg        <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept_c) begin
                cnt       <= '0;
                p1        <= '0;
                mc1       <= PW1'(yc_c);
                mp1       <= 17'h1_0000 - yc_c;
                y_clamped <= clamp_c;
`ifdef SIGDERIV_ERR_MUL_EN
                sg        <= g[DW-1];
                mc2       <= PW2'(g[DW-1] ? DW'(-g) : g);
`endif
            end else if (state == MUL1) begin
                p1  <= p1_sum;
                mc1 <= mc1 << 1;
                mp1 <= mp1 >> 1;
                cnt <= (cnt == CW'(16)) ? '0 : cnt + CW'(1);
`ifdef SIGDERIV_ERR_MUL_EN
                if (cnt == CW'(16)) begin
                    // d never exceeds 0x4000, so 15 bits of p1[33:16] suffice
                    mp2 <= p1_sum[16 +: DDW];
                    p2  <= '0;
                end
            end else if (state == MUL2) begin
                p2  <= p2_sum;
                mc2 <= mc2 << 1;
                mp2 <= mp2 >> 1;
                cnt <= cnt + CW'(1);
`endif
            end else if (state == FIN) begin
`ifdef SIGDERIV_ERR_MUL_EN
                delta <= sg ? -{1'b0, m_c} : {1'b0, m_c};
`else
                delta <= DW'(p1[PW1-1:16]);
`endif
            end
        end
    end

endmodule
